// File: rtl/iccm_loader_pkg.sv
// ============================================================================
// iccm_loader_pkg : shared types and constants for the ICCM boot loader
// Rev 1.0
// ============================================================================
`default_nettype none

package iccm_loader_pkg;

   localparam int         IccmHdrWidth  = 32;
   localparam logic [3:0] IccmWmaskFull = 4'hF;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StHdr  = 3'd1,
      StData = 3'd2,
`ifdef ICCM_LOADER_CHECKSUM_EN
      StCsum = 3'd3,
`endif
      StDone = 3'd4,
      StErr  = 3'd5
   } state_e;

endpackage

`default_nettype wire

// File: rtl/iccm_loader_byte_packer.sv
// ============================================================================
// byte_packer : 8-to-32 little-endian packer; word_valid_o pulses with the 4th byte
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_packer
   import iccm_loader_pkg::*;
(
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    clear_i,
   input  logic                    valid_i,
   input  logic                    ready_i,
   input  logic [7:0]              data_i,
   output logic                    word_valid_o,
   output logic [IccmHdrWidth-1:0] word_o
);

   logic [1:0]  r_cnt;
   logic [23:0] r_pack;
   logic        w_fire;

   assign w_fire       = valid_i && ready_i;
   // The 4th byte is forwarded straight from the input, so the word is usable in its accept cycle.
   assign word_valid_o = w_fire && (r_cnt == 2'd3);
   assign word_o       = {data_i, r_pack};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt  <= 2'd0;
         r_pack <= 24'd0;
      end else if (clear_i) begin
         r_cnt  <= 2'd0;
      end else if (w_fire) begin
         r_cnt <= r_cnt + 2'd1;
         case (r_cnt)
            2'd0:    r_pack[7:0]   <= data_i;
            2'd1:    r_pack[15:8]  <= data_i;
            2'd2:    r_pack[23:16] <= data_i;
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/iccm_loader.sv
// ============================================================================
// iccm_loader : boot-time byte-stream to instruction-memory writer
// Optional image checksum when ICCM_LOADER_CHECKSUM_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

module iccm_loader
   import iccm_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DEPTH      = 4096
)(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  rx_valid_i,
   input  logic [7:0]            rx_data_i,
   output logic                  rx_ready_o,
   output logic                  req_o,
   output logic                  we_o,
   output logic [3:0]            wmask_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [31:0]           wdata_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o
);

   localparam logic [ADDR_WIDTH:0] c_idx_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_e                  r_state;
   logic                    r_req;
   logic                    r_we;
   logic [3:0]              r_wmask;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [31:0]             r_wdata;
   logic [ADDR_WIDTH:0]     r_idx;
   logic [ADDR_WIDTH:0]     r_len;
`ifdef ICCM_LOADER_CHECKSUM_EN
   logic [31:0]             r_xor;
`endif

   logic                    w_clear;
   logic                    w_word_valid;
   logic [IccmHdrWidth-1:0] w_word;

   assign w_clear = start_i &&
                    ((r_state == StIdle) || (r_state == StDone) || (r_state == StErr));

   byte_packer u_packer (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (w_clear),
      .valid_i      (rx_valid_i),
      .ready_i      (rx_ready_o),
      .data_i       (rx_data_i),
      .word_valid_o (w_word_valid),
      .word_o       (w_word)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_wmask <= 4'h0;
         r_addr  <= '0;
         r_wdata <= 32'd0;
         r_idx   <= '0;
         r_len   <= '0;
`ifdef ICCM_LOADER_CHECKSUM_EN
         r_xor   <= 32'd0;
`endif
      end else begin
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_wmask <= 4'h0;
         case (r_state)
            StIdle, StDone, StErr: begin
               if (start_i) begin
                  r_state <= StHdr;
                  r_idx   <= '0;
`ifdef ICCM_LOADER_CHECKSUM_EN
                  r_xor   <= 32'd0;
`endif
               end
            end
            StHdr: begin
               if (w_word_valid) begin
                  if (w_word > IccmHdrWidth'(DEPTH)) begin
                     r_state <= StErr;
                  end else if (w_word == '0) begin
`ifdef ICCM_LOADER_CHECKSUM_EN
                     r_state <= StCsum;
`else
                     r_state <= StDone;
`endif
                  end else begin
                     r_state <= StData;
                     r_len   <= w_word[ADDR_WIDTH:0];
                  end
               end
            end
            StData: begin
               if (w_word_valid) begin
                  r_req   <= 1'b1;
                  r_we    <= 1'b1;
                  r_wmask <= IccmWmaskFull;
                  r_addr  <= r_idx[ADDR_WIDTH-1:0];
                  r_wdata <= w_word;
                  r_idx   <= r_idx + c_idx_one;
`ifdef ICCM_LOADER_CHECKSUM_EN
                  r_xor   <= r_xor ^ w_word;
`endif
               end else if (r_req && (r_idx == r_len)) begin
                  // Leave only once the final write cycle has been presented.
`ifdef ICCM_LOADER_CHECKSUM_EN
                  r_state <= StCsum;
`else
                  r_state <= StDone;
`endif
               end
            end
`ifdef ICCM_LOADER_CHECKSUM_EN
            StCsum: begin
               if (w_word_valid) begin
                  r_state <= (w_word == r_xor) ? StDone : StErr;
               end
            end
`endif
            default: r_state <= StIdle;
         endcase
      end
   end

   assign busy_o     = (r_state == StHdr) || (r_state == StData)
`ifdef ICCM_LOADER_CHECKSUM_EN
                       || (r_state == StCsum)
`endif
                       ;
   assign rx_ready_o = busy_o;
   assign done_o     = (r_state == StDone);
   assign err_o      = (r_state == StErr);
   assign req_o      = r_req;
   assign we_o       = r_we;
   assign wmask_o    = r_wmask;
   assign addr_o     = r_addr;
   assign wdata_o    = r_wdata;

endmodule

`default_nettype wire

// File: doc/iccm_loader.md
# iccm_loader

Boot-time writer for the instruction memory. Receives the program as a byte stream from a boot peripheral (UART/SPI receiver), packs bytes little-endian into 32-bit words, and drives the instruction memory's req/we/wmask/addr/wdata port to write them sequentially from word address 0. On completion it raises `done_o`, the gate that releases the core from reset. With the checksum option compiled in, it also validates the image.

## Interface
- `ADDR_WIDTH`, 12: word-address width of the instruction memory.
- `DEPTH`, 4096: maximum program length in words (≤ 2^ADDR_WIDTH).
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  pulse; begins a load when idle, done or errored.
- `rx_valid_i`  in  1  byte-stream valid.
- `rx_data_i`  in  8  byte-stream data.
- `rx_ready_o`  out  1  byte accepted when `rx_valid_i && rx_ready_o`.
- `req_o`  out  1  memory request (chip select).
- `we_o`  out  1  memory write enable.
- `wmask_o`  out  4  byte write mask.
- `addr_o`  out  ADDR_WIDTH  word address.
- `wdata_o`  out  32  write data.
- `busy_o`  out  1  high in HDR/DATA/CSUM.
- `done_o`  out  1  high in DONE.
- `err_o`  out  1  high in ERR.

## Operation
- States: IDLE, HDR, DATA, CSUM (only when the macro is defined), DONE, ERR.
- `start_i` in IDLE/DONE/ERR: go to HDR; clear the byte counter, word index and checksum. `start_i` in HDR/DATA/CSUM is ignored.
- `rx_ready_o` = 1 in HDR, DATA and CSUM; 0 otherwise. Bytes offered outside these states are not consumed.
- Packing: a 2-bit byte counter. Byte k of a word lands in bits [8k+7:8k]. The 4th accepted byte completes the word.
- HDR: the completed word is the length N.
  - N > DEPTH: go to ERR.
  - N == 0: go to DONE (or CSUM if enabled).
  - Otherwise: go to DATA.
- DATA: each completed word is registered into `wdata_o`. The next cycle is a write cycle: `req_o=1`, `we_o=1`, `wmask_o=4'hF`, `addr_o`=word index. The index increments after each write.
- After the write at index N-1, go to DONE (or CSUM if enabled).
- Index arithmetic is ADDR_WIDTH+1 bits wide, so N == DEPTH == 4096 terminates correctly with no wrap.
- Outside write cycles: `req_o=0`, `we_o=0`, `wmask_o=0`. `addr_o` and `wdata_o` hold their last values.
- Reset mid-load: all state returns to IDLE and all outputs go to their reset values. Memory contents already written are left as-is.

## Timing
- Reset values: `req_o`, `we_o`, `wmask_o`, `addr_o`, `wdata_o`, `rx_ready_o`, `busy_o`, `done_o`, `err_o` all 0; state IDLE.
- `start_i` at edge t: state is HDR and `rx_ready_o`=1 from t+1.
- Write cycle occurs exactly one cycle after acceptance of a word's 4th byte.
- Sustained throughput is 1 byte/cycle. Byte acceptance continues during write cycles because the packing register is separate from `wdata_o`.
- `rx_valid_i` bubbles stall packing only; no timeout.
- `done_o`/`err_o` assert the cycle after the last write (or the last header/checksum byte). They stay high until `start_i` or reset.
- The memory is always ready: a write completes in its request cycle and produces no read response.

## Configuration
- `ICCM_LOADER_CHECKSUM_EN` defined:
  - After the N data words, CSUM collects one further 4-byte word.
  - That word is compared to the XOR of all N data words (header excluded; the XOR of zero words is 0).
  - Equal: DONE. Different: ERR.
  - No write cycle is issued for the checksum word.
- Undefined: the CSUM state and XOR register are absent. DATA (or an N == 0 header) goes directly to DONE.

## Structure
- `iccm_loader_pkg` holds:
  - the state enum;
  - `IccmWmaskFull = 4'hF`;
  - the header width constant.
- One sub-module, `byte_packer`, is natural: an 8-to-32 little-endian packer with `valid`/`ready` in and a one-cycle `word_valid` pulse out, plus a `clear` input.
- The FSM, index counter, checksum and memory-port registers live in `iccm_loader`.

## Test plan
- Header `02 00 00 00`, then bytes `78 56 34 12 EF BE AD DE` back-to-back: two write cycles, addr 0/`0x12345678` then addr 1/`0xDEADBEEF`, `wmask_o=4'hF`; `done_o`=1 one cycle after the second write.
- Header `00 00 00 00`: no `req_o` pulse; `done_o`=1 the cycle after the 4th byte.
- Header `01 10 00 00` (N=4097): `err_o`=1, no write cycles, `rx_ready_o`=0 afterwards.
- Same image as the first test with random 0–3 cycle `rx_valid_i` gaps: identical write sequence; `busy_o` high throughout.
- `rst_ni` low after the first write of a 3-word load: all outputs 0 immediately. A subsequent `start_i` plus full image completes with writes from addr 0.
- With `ICCM_LOADER_CHECKSUM_EN`, the first test's image plus checksum `97 E8 99 CC` (XOR = `0xCC99E897`): `done_o`=1. Checksum `00 00 00 00`: `err_o`=1 and no third write.
